escalonador_andares: RTL and testbench

- Floor-request scheduler for the elevator; shares the single car among all floor buttons (internal cabin and external hall calls).
- Runs on the fast system clock.
- Advances car position and door timing only on single-cycle tick enables derived from the frequency divider's slow outputs: tick_mover from the ~0.75 Hz output, tick_porta likewise.
- Drives motor, door and floor outputs consumed by the display/LED logic; SCAN (elevator) policy.

---
 rtl/escalonador_andares_pkg.sv | 9 +
 rtl/escalonador_andares_if.sv | 23 ++
 rtl/escalonador_andares_temporizador_porta.sv | 26 ++
 rtl/escalonador_andares.sv | 154 +++++++++++++++
 tb/tb_escalonador_andares.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/escalonador_andares_pkg.sv
// escalonador_pkg: definitions shared by the elevator floor scheduler.
//   estado_t   - car controller states
//   DIR_SUBIR / DIR_DESCER - encoding of the direcao output
package escalonador_pkg;
  typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA_ABERTA} estado_t;

  localparam logic DIR_SUBIR  = 1'b1;
  localparam logic DIR_DESCER = 1'b0;
endpackage

// File: rtl/escalonador_andares_if.sv
// escalonador_andares_if: button inputs and car status outputs of the scheduler.
//   req_interno/req_externo - debounced cabin / hall buttons, one bit per floor
//   andar_atual, motor_subir, motor_descer, porta_aberta, pendentes, direcao - status
//   master: button/display side; slave: scheduler side.
interface escalonador_andares_if #(parameter int N_ANDARES = 4);
  localparam int W_ANDAR = (N_ANDARES > 2) ? $clog2(N_ANDARES) : 1;

  logic [N_ANDARES-1:0] req_interno;
  logic [N_ANDARES-1:0] req_externo;
  logic [W_ANDAR-1:0]   andar_atual;
  logic                 motor_subir;
  logic                 motor_descer;
  logic                 porta_aberta;
  logic [N_ANDARES-1:0] pendentes;
  logic                 direcao;

  modport master (output req_interno, req_externo,
                  input  andar_atual, motor_subir, motor_descer, porta_aberta,
                         pendentes, direcao);
  modport slave  (input  req_interno, req_externo,
                  output andar_atual, motor_subir, motor_descer, porta_aberta,
                         pendentes, direcao);
endinterface

// File: rtl/escalonador_andares_temporizador_porta.sv
// temporizador_porta: door-open timer. Loadable down-counter stepped by tick_porta.
//   clock, reset (async, active low)
//   i_carga - reload to TICKS_PORTA (wins over i_tick)
//   i_tick  - decrement enable
//   o_fim   - counter is at its last step (==1); the next tick ends the door period
module temporizador_porta #(
  parameter int TICKS_PORTA = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_carga,
  input  logic i_tick,
  output logic o_fim
);
  localparam int W_CNT = $clog2(TICKS_PORTA + 1);

  logic [W_CNT-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     r_cnt <= '0;
    else if (i_carga)               r_cnt <= W_CNT'(TICKS_PORTA);
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_fim = (r_cnt == W_CNT'(1));
endmodule

// File: rtl/escalonador_andares.sv
// escalonador_andares: SCAN floor scheduler sharing one car among all buttons.
//   clock, reset (async, active low), tick_mover (one floor per pulse),
//   tick_porta (door timer step), bus (escalonador_andares_if.slave).
//   Optional: ESCALONADOR_EMERGENCIA_EN adds input emergencia - drop all calls,
//   return to floor 0 and hold the door open there until it falls.
module escalonador_andares
  import escalonador_pkg::*;
#(
  parameter int N_ANDARES   = 4,
  parameter int TICKS_PORTA = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_mover,
  input  logic tick_porta,
`ifdef ESCALONADOR_EMERGENCIA_EN
  input  logic emergencia,
`endif
  escalonador_andares_if.slave bus
);
  localparam int W_ANDAR = (N_ANDARES > 2) ? $clog2(N_ANDARES) : 1;

  function automatic logic tem_acima(input logic [N_ANDARES-1:0] p, input logic [W_ANDAR-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) if (i > int'(f)) r = r | p[i];
    return r;
  endfunction

  function automatic logic tem_abaixo(input logic [N_ANDARES-1:0] p, input logic [W_ANDAR-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) if (i < int'(f)) r = r | p[i];
    return r;
  endfunction

  estado_t              r_estado, w_estado_nx, w_d_estado;
  logic [W_ANDAR-1:0]   r_andar, w_andar_nx, w_sobe, w_desce;
  logic [N_ANDARES-1:0] r_pend, w_req, w_limpa;
  logic                 r_dir, w_dir_nx, w_d_dir;
  logic                 w_carga, w_fim, w_emerg;

`ifdef ESCALONADOR_EMERGENCIA_EN
  assign w_emerg = emergencia;
`else
  assign w_emerg = 1'b0;
`endif

  assign w_req   = w_emerg ? '0 : (bus.req_interno | bus.req_externo);
  assign w_sobe  = r_andar + 1'b1;
  assign w_desce = r_andar - 1'b1;

  // Shared SCAN decision: keep going the current way while calls remain that way.
  always_comb begin
    w_d_estado = PARADO;
    w_d_dir    = r_dir;
    if (w_emerg) begin
      // Emergency: always head to ground; at ground the door opens and holds.
      if (r_andar != '0) begin w_d_estado = DESCENDO; w_d_dir = DIR_DESCER; end
      else                     w_d_estado = PORTA_ABERTA;
    end else if (r_dir == DIR_SUBIR) begin
      if (tem_acima(r_pend, r_andar))        w_d_estado = SUBINDO;
      else if (tem_abaixo(r_pend, r_andar)) begin w_d_estado = DESCENDO; w_d_dir = DIR_DESCER; end
    end else begin
      if (tem_abaixo(r_pend, r_andar))       w_d_estado = DESCENDO;
      else if (tem_acima(r_pend, r_andar))  begin w_d_estado = SUBINDO; w_d_dir = DIR_SUBIR; end
    end
  end

  always_comb begin
    w_estado_nx = r_estado;
    w_andar_nx  = r_andar;
    w_dir_nx    = r_dir;
    w_limpa     = '0;
    w_carga     = 1'b0;
    unique case (r_estado)
      PARADO: begin
        w_limpa[r_andar] = 1'b1;  // a call at the current floor is served, never latched
        if (w_req[r_andar] || r_pend[r_andar]) begin
          w_estado_nx = PORTA_ABERTA;
          w_carga     = 1'b1;
        end else begin
          w_estado_nx = w_d_estado;
          w_dir_nx    = w_d_dir;
          w_carga     = (w_d_estado == PORTA_ABERTA);
        end
      end
      SUBINDO: begin
        if (w_emerg) begin
          // Reverse at once; at ground there is nowhere lower to go.
          if (r_andar == '0) begin w_estado_nx = PORTA_ABERTA; w_carga = 1'b1; end
          else begin w_estado_nx = DESCENDO; w_dir_nx = DIR_DESCER; end
        end else if (tick_mover) begin
          w_andar_nx = w_sobe;
          if (r_pend[w_sobe] || w_req[w_sobe]) begin
            w_estado_nx      = PORTA_ABERTA;
            w_limpa[w_sobe]  = 1'b1;
            w_carga          = 1'b1;
          end
        end
      end
      DESCENDO: begin
        if (tick_mover) begin
          w_andar_nx = w_desce;
          if (r_pend[w_desce] || w_req[w_desce] || (w_emerg && w_desce == '0)) begin
            w_estado_nx      = PORTA_ABERTA;
            w_limpa[w_desce] = 1'b1;
            w_carga          = 1'b1;
          end
        end
      end
      PORTA_ABERTA: begin
        w_limpa[r_andar] = 1'b1;
        // Reload beats a coincident tick; emergency at ground keeps the door held.
        if (w_req[r_andar] || (w_emerg && r_andar == '0)) begin
          w_carga = 1'b1;
        end else if (tick_porta && w_fim) begin
          w_estado_nx = w_d_estado;
          w_dir_nx    = w_d_dir;
        end
      end
      default: w_estado_nx = PARADO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= PARADO;
      r_andar  <= '0;
      r_pend   <= '0;
      r_dir    <= DIR_SUBIR;
    end else begin
      r_estado <= w_estado_nx;
      r_andar  <= w_andar_nx;
      r_pend   <= w_emerg ? '0 : ((r_pend | w_req) & ~w_limpa);
      r_dir    <= w_dir_nx;
    end
  end

  temporizador_porta #(.TICKS_PORTA(TICKS_PORTA)) u_porta (
    .clock   (clock),
    .reset   (reset),
    .i_carga (w_carga),
    .i_tick  (tick_porta && r_estado == PORTA_ABERTA),
    .o_fim   (w_fim)
  );

  assign bus.andar_atual  = r_andar;
  assign bus.motor_subir  = (r_estado == SUBINDO);
  assign bus.motor_descer = (r_estado == DESCENDO);
  assign bus.porta_aberta = (r_estado == PORTA_ABERTA);
  assign bus.pendentes    = r_pend;
  assign bus.direcao      = r_dir;
endmodule

// File: tb/tb_escalonador_andares.sv
module tb_escalonador_andares;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick_mover = 1'b0;
  logic tick_porta = 1'b0;
`ifdef ESCALONADOR_EMERGENCIA_EN
  logic emergencia = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;
  logic viol = 1'b0;

  escalonador_andares_if #(.N_ANDARES(4)) bus ();

  escalonador_andares #(.N_ANDARES(4), .TICKS_PORTA(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick_mover (tick_mover),
    .tick_porta (tick_porta),
`ifdef ESCALONADOR_EMERGENCIA_EN
    .emergencia (emergencia),
`endif
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // Safety invariants sampled on the falling edge.
  always @(negedge clock)
    if (reset && ((bus.motor_subir && bus.motor_descer) ||
                  ((bus.motor_subir || bus.motor_descer) && bus.porta_aberta)))
      viol = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_interno = '0;
    bus.req_externo = '0;
    tick_mover = 1'b0;
    tick_porta = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic pulse_mover(input int n = 1);
    repeat (n) begin tick_mover = 1'b1; step(1); tick_mover = 1'b0; step(1); end
  endtask

  task automatic pulse_porta(input int n = 1);
    repeat (n) begin tick_porta = 1'b1; step(1); tick_porta = 1'b0; step(1); end
  endtask

  task automatic chamar(input logic [3:0] r);
    bus.req_interno = r;
    step(1);
    bus.req_interno = '0;
    step(1);
  endtask

  initial begin
    bus.req_interno = '0;
    bus.req_externo = '0;

    // Reset with all hall buttons held.
    reset = 1'b0;
    bus.req_externo = 4'b1111;
    step(2);
    chk("rst_andar",  32'(bus.andar_atual),  32'd0);
    chk("rst_subir",  32'(bus.motor_subir),  32'd0);
    chk("rst_descer", 32'(bus.motor_descer), 32'd0);
    chk("rst_porta",  32'(bus.porta_aberta), 32'd0);
    chk("rst_pend",   32'(bus.pendentes),    32'd0);
    chk("rst_dir",    32'(bus.direcao),      32'd1);
    reset = 1'b1;
    step(1);
    // Floor 0 call is served at once (door), the rest are latched.
    chk("pos_rst_pend",  32'(bus.pendentes),    32'hE);
    chk("pos_rst_porta", 32'(bus.porta_aberta), 32'd1);
    bus.req_externo = '0;

    // Single trip 0 -> 2.
    do_reset();
    bus.req_interno = 4'b0100;
    step(1);
    bus.req_interno = '0;
    chk("b_pend",   32'(bus.pendentes),   32'h4);
    chk("b_parado", 32'(bus.motor_subir), 32'd0);
    step(1);
    chk("b_subindo", 32'(bus.motor_subir), 32'd1);
    pulse_mover(1);
    chk("b_andar1", 32'(bus.andar_atual), 32'd1);
    pulse_mover(1);
    chk("b_andar2", 32'(bus.andar_atual),  32'd2);
    chk("b_porta",  32'(bus.porta_aberta), 32'd1);
    chk("b_limpo",  32'(bus.pendentes),    32'd0);
    pulse_porta(2);
    chk("b_porta2", 32'(bus.porta_aberta), 32'd1);
    pulse_porta(1);
    chk("b_fecha",  32'(bus.porta_aberta), 32'd0);
    chk("b_motor",  32'(bus.motor_subir | bus.motor_descer), 32'd0);

    // SCAN: going up to 3, call at 0 arrives at floor 1.
    do_reset();
    chamar(4'b1000);
    pulse_mover(1);
    chk("c_andar1", 32'(bus.andar_atual), 32'd1);
    bus.req_externo = 4'b0001;
    step(1);
    bus.req_externo = '0;
    chk("c_pend", 32'(bus.pendentes), 32'h9);
    pulse_mover(1);
    chk("c_andar2", 32'(bus.andar_atual), 32'd2);
    pulse_mover(1);
    chk("c_andar3", 32'(bus.andar_atual),  32'd3);
    chk("c_porta3", 32'(bus.porta_aberta), 32'd1);
    chk("c_pend3",  32'(bus.pendentes),    32'h1);
    pulse_porta(3);
    chk("c_descendo", 32'(bus.motor_descer), 32'd1);
    chk("c_dir",      32'(bus.direcao),      32'd0);
    pulse_mover(1);
    chk("c_d2", 32'(bus.andar_atual), 32'd2);
    pulse_mover(1);
    chk("c_d1", 32'(bus.andar_atual), 32'd1);
    pulse_mover(1);
    chk("c_d0",     32'(bus.andar_atual),  32'd0);
    chk("c_porta0", 32'(bus.porta_aberta), 32'd1);
    chk("c_pend0",  32'(bus.pendentes),    32'd0);

    // Reload beats a coincident tick_porta at counter==1.
    do_reset();
    chamar(4'b0100);
    pulse_mover(2);
    pulse_porta(2);
    bus.req_externo = 4'b0100;
    tick_porta = 1'b1;
    step(1);
    bus.req_externo = '0;
    tick_porta = 1'b0;
    step(1);
    chk("d_porta",  32'(bus.porta_aberta), 32'd1);
    chk("d_pend",   32'(bus.pendentes),    32'd0);
    pulse_porta(2);
    chk("d_porta2", 32'(bus.porta_aberta), 32'd1);
    pulse_porta(1);
    chk("d_fecha",  32'(bus.porta_aberta), 32'd0);

    // Top floor call while idle at the top.
    do_reset();
    chamar(4'b1000);
    pulse_mover(3);
    pulse_porta(3);
    chk("e_parado", 32'(bus.porta_aberta), 32'd0);
    chk("e_andar",  32'(bus.andar_atual),  32'd3);
    bus.req_interno = 4'b1000;
    step(1);
    bus.req_interno = '0;
    chk("e_porta", 32'(bus.porta_aberta), 32'd1);
    chk("e_pend",  32'(bus.pendentes),    32'd0);
    pulse_mover(2);
    chk("e_andar_fixo", 32'(bus.andar_atual), 32'd3);
    chk("e_subir",      32'(bus.motor_subir), 32'd0);

`ifdef ESCALONADOR_EMERGENCIA_EN
    do_reset();
    chamar(4'b1000);
    pulse_mover(3);
    bus.req_interno = 4'b0110;
    step(1);
    bus.req_interno = '0;
    chk("f_pend", 32'(bus.pendentes), 32'h6);
    emergencia = 1'b1;
    step(1);
    chk("f_limpo", 32'(bus.pendentes), 32'd0);
    pulse_porta(3);
    chk("f_descendo", 32'(bus.motor_descer), 32'd1);
    pulse_mover(3);
    chk("f_andar0", 32'(bus.andar_atual),  32'd0);
    chk("f_porta",  32'(bus.porta_aberta), 32'd1);
    pulse_porta(4);
    chk("f_retida", 32'(bus.porta_aberta), 32'd1);
    emergencia = 1'b0;
    step(1);
    pulse_porta(3);
    chk("f_fecha", 32'(bus.porta_aberta), 32'd0);
`endif

    chk("invariante", 32'(viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
